// File: rtl/adma_pkg.sv
// adma_pkg: shared definitions for the ADMA2 descriptor engine.
//   - one-hot engine state encodings
//   - descriptor action codes (NOP / RSV / TRAN / LINK)
//   - ADMA Error Status state codes reported on err_state
//   - bit positions of the descriptor attribute / length / address fields
package adma_pkg;

  typedef enum logic [3:0] {
    ST_STOP = 4'b0001,
    ST_FDS  = 4'b0010,
    ST_CADR = 4'b0100,
    ST_TFR  = 4'b1000
  } adma_state_e;

  typedef enum logic [1:0] {
    ACT_NOP  = 2'b00,
    ACT_RSV  = 2'b01,
    ACT_TRAN = 2'b10,
    ACT_LINK = 2'b11
  } adma_act_e;

  // State the engine was in when an error was detected
  localparam logic [1:0] ERR_ST_STOP = 2'b00;
  localparam logic [1:0] ERR_ST_FDS  = 2'b01;
  localparam logic [1:0] ERR_ST_TFR  = 2'b11;

  // Descriptor field positions
  localparam int DESC_VALID_BIT = 0;
  localparam int DESC_END_BIT   = 1;
  localparam int DESC_INT_BIT   = 2;
  localparam int DESC_ACT_LSB   = 4;
  localparam int DESC_ACT_MSB   = 5;
  localparam int DESC_LEN_LSB   = 16;
  localparam int DESC_LEN_MSB   = 31;
  localparam int DESC_ADDR_LSB  = 32;

endpackage

// File: rtl/adma_beat_ctr.sv
// adma_beat_ctr: data-beat address / byte counter for one TRAN descriptor.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   load             load a new descriptor (address + length)
//   load_addr        descriptor data address
//   load_len         descriptor length field (0 encodes 65536 bytes)
//   beat             one data beat accepted this cycle
//   dat_addr         address of the current beat
//   dat_last         current beat is the final one of the descriptor
module adma_beat_ctr
  import adma_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int BEAT_BYTES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [15:0]       load_len,
  input  logic              beat,
  output logic [ADDR_W-1:0] dat_addr,
  output logic              dat_last
);

  localparam logic [16:0] BEAT_LEN = 17'(BEAT_BYTES);

  logic [ADDR_W-1:0] dat_addr_r;
  logic [16:0]       remaining_r;
  logic [16:0]       step_s;

  // Bytes consumed by the current beat: a short tail beat only takes what is left
  always_comb begin
    step_s = BEAT_LEN;
    if (remaining_r <= BEAT_LEN) begin
      step_s = remaining_r;
    end else begin
      step_s = BEAT_LEN;
    end
  end

  // Address and remaining-length registers; a zero length field means 64 KiB
  always_ff @(posedge clk) begin
    if (reset) begin
      dat_addr_r  <= '0;
      remaining_r <= 17'd0;
    end else if (load) begin
      dat_addr_r  <= load_addr;
      remaining_r <= (load_len == 16'd0) ? 17'h10000 : {1'b0, load_len};
    end else if (beat) begin
      dat_addr_r  <= dat_addr_r + ADDR_W'(BEAT_BYTES);
      remaining_r <= remaining_r - step_s;
    end
  end

  assign dat_addr = dat_addr_r;
  assign dat_last = (remaining_r <= BEAT_LEN);

endmodule

// File: rtl/adma2_engine.sv
// adma2_engine: SD Host ADMA2 descriptor-processing engine.
// Walks a descriptor table in system memory, executing NOP/RSV/TRAN/LINK
// descriptors and issuing data beats for TRAN descriptors.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start / cont / abort       command pulses (run from init_addr / resume / stop)
//   stop_at_gap                level: halt at the next descriptor boundary
//   init_addr                  descriptor table base loaded by start
//   desc_req/addr/ack/data     descriptor fetch handshake
//   dat_req/addr/last/ack      data beat handshake
//   sys_addr                   ADMA System Address register
//   busy                       engine not in ST_STOP
//   dma_int, xfer_complete, adma_err   single-cycle event pulses
//   err_state                  ADMA Error Status state code, held until next start
module adma2_engine
  import adma_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int BEAT_BYTES = 4,
  parameter int DESC_W     = 32 + ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cont,
  input  logic              abort,
  input  logic              stop_at_gap,
  input  logic [ADDR_W-1:0] init_addr,
  output logic              desc_req,
  output logic [ADDR_W-1:0] desc_addr,
  input  logic              desc_ack,
  input  logic [DESC_W-1:0] desc_data,
  output logic              dat_req,
  output logic [ADDR_W-1:0] dat_addr,
  output logic              dat_last,
  input  logic              dat_ack,
  output logic [ADDR_W-1:0] sys_addr,
  output logic              busy,
  output logic              dma_int,
  output logic              xfer_complete,
  output logic              adma_err,
  output logic [1:0]        err_state
);

  localparam int DESC_BYTES = DESC_W / 8;

  adma_state_e       state_r, state_nxt_s;
  logic [ADDR_W-1:0] sys_addr_r, sys_addr_nxt_s;
  logic [1:0]        err_state_r, err_state_nxt_s;
  logic              dma_int_r, dma_int_nxt_s;
  logic              xfer_r, xfer_nxt_s;
  logic              adma_err_r, adma_err_nxt_s;

  // Captured descriptor fields (valid bit is consumed at capture time)
  logic              desc_end_r;
  logic              desc_int_r;
  adma_act_e         desc_act_r;
  logic [15:0]       desc_len_r;
  logic [ADDR_W-1:0] desc_fld_addr_r;

  logic              desc_load_s;
  logic              beat_load_s;
  logic              beat_s;
  logic              unused_desc_bits_s;

  assign unused_desc_bits_s = ^{desc_data[15:6], desc_data[3]};

  // Next-state, next sys_addr / err_state and event pulses
  always_comb begin
    state_nxt_s     = state_r;
    sys_addr_nxt_s  = sys_addr_r;
    err_state_nxt_s = err_state_r;
    dma_int_nxt_s   = 1'b0;
    xfer_nxt_s      = 1'b0;
    adma_err_nxt_s  = 1'b0;
    desc_load_s     = 1'b0;
    beat_load_s     = 1'b0;
    if (abort) begin
      // Immediate stop from any state, no events reported
      state_nxt_s = ST_STOP;
    end else begin
      case (state_r)
        ST_STOP: begin
          if (start) begin
            sys_addr_nxt_s  = init_addr;
            err_state_nxt_s = ERR_ST_STOP;
            state_nxt_s     = ST_FDS;
          end else if (cont) begin
            state_nxt_s = ST_FDS;
          end else begin
            state_nxt_s = ST_STOP;
          end
        end
        ST_FDS: begin
          if (desc_ack) begin
            if (desc_data[DESC_VALID_BIT]) begin
              desc_load_s = 1'b1;
              state_nxt_s = ST_CADR;
            end else begin
              adma_err_nxt_s  = 1'b1;
              dma_int_nxt_s   = 1'b1;
              err_state_nxt_s = ERR_ST_FDS;
              state_nxt_s     = ST_STOP;
            end
          end else begin
            state_nxt_s = ST_FDS;
          end
        end
        ST_CADR: begin
          if (desc_act_r == ACT_TRAN) begin
            sys_addr_nxt_s = sys_addr_r + ADDR_W'(DESC_BYTES);
            beat_load_s    = 1'b1;
            state_nxt_s    = ST_TFR;
          end else begin
            if (desc_act_r == ACT_LINK) begin
              sys_addr_nxt_s = desc_fld_addr_r;
            end else begin
              sys_addr_nxt_s = sys_addr_r + ADDR_W'(DESC_BYTES);
            end
            if (desc_end_r) begin
              xfer_nxt_s  = 1'b1;
              state_nxt_s = ST_STOP;
            end else if (stop_at_gap) begin
              state_nxt_s = ST_STOP;
            end else begin
              state_nxt_s = ST_FDS;
            end
          end
        end
        ST_TFR: begin
          if (dat_ack && dat_last) begin
            dma_int_nxt_s = desc_int_r;
            if (desc_end_r) begin
              xfer_nxt_s  = 1'b1;
              state_nxt_s = ST_STOP;
            end else if (stop_at_gap) begin
              state_nxt_s = ST_STOP;
            end else begin
              state_nxt_s = ST_FDS;
            end
          end else begin
            state_nxt_s = ST_TFR;
          end
        end
        default: begin
          state_nxt_s = ST_STOP;
        end
      endcase
    end
  end

  // State, address, error-status and pulse registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_STOP;
      sys_addr_r  <= '0;
      err_state_r <= ERR_ST_STOP;
      dma_int_r   <= 1'b0;
      xfer_r      <= 1'b0;
      adma_err_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      sys_addr_r  <= sys_addr_nxt_s;
      err_state_r <= err_state_nxt_s;
      dma_int_r   <= dma_int_nxt_s;
      xfer_r      <= xfer_nxt_s;
      adma_err_r  <= adma_err_nxt_s;
    end
  end

  // Descriptor capture on an accepted fetch
  always_ff @(posedge clk) begin
    if (reset) begin
      desc_end_r      <= 1'b0;
      desc_int_r      <= 1'b0;
      desc_act_r      <= ACT_NOP;
      desc_len_r      <= 16'd0;
      desc_fld_addr_r <= '0;
    end else if (desc_load_s) begin
      desc_end_r      <= desc_data[DESC_END_BIT];
      desc_int_r      <= desc_data[DESC_INT_BIT];
      desc_act_r      <= adma_act_e'(desc_data[DESC_ACT_MSB:DESC_ACT_LSB]);
      desc_len_r      <= desc_data[DESC_LEN_MSB:DESC_LEN_LSB];
      desc_fld_addr_r <= desc_data[DESC_W-1:DESC_ADDR_LSB];
    end
  end

  assign beat_s = (state_r == ST_TFR) && dat_ack && !abort;

  adma_beat_ctr #(
    .ADDR_W     (ADDR_W),
    .BEAT_BYTES (BEAT_BYTES)
  ) u_beat_ctr (
    .clk       (clk),
    .reset     (reset),
    .load      (beat_load_s),
    .load_addr (desc_fld_addr_r),
    .load_len  (desc_len_r),
    .beat      (beat_s),
    .dat_addr  (dat_addr),
    .dat_last  (dat_last)
  );

  assign desc_req      = (state_r == ST_FDS);
  assign desc_addr     = sys_addr_r;
  assign dat_req       = (state_r == ST_TFR);
  assign sys_addr      = sys_addr_r;
  assign busy          = (state_r != ST_STOP);
  assign dma_int       = dma_int_r;
  assign xfer_complete = xfer_r;
  assign adma_err      = adma_err_r;
  assign err_state     = err_state_r;

endmodule
